fir_seq_ctrl: RTL

Sequencer for the 17-tap FIR low-pass in the FM demodulator chain. It accepts baseband samples over a valid/ready handshake and issues the filter's sample strobe (start and merge-finished). It captures the filter output after its pipeline latency, discards unprimed results and decimates by DEC. Decimated results go into a 2-entry output FIFO with backpressure. It also provides a zero-stuffing flush that clears the filter history without resetting it.

---
 rtl/fir_seq_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fir_seq_ctrl.sv
// Sample sequencer for the 17-tap FM-demod low-pass FIR: strobes the filter,
// drops unprimed results, decimates into a 2-entry FWFT output FIFO.
module fir_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int TAPS  = 17,
    parameter int LAT   = 2,
    parameter int DEC   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush_i,
    output logic [WIDTH-1:0] fir_data_o,
    output logic             fir_start_o,
    output logic             fir_merge_o,
    input  logic [WIDTH-1:0] fir_data_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy_o,
    output logic             primed_o
);
    // state   | meaning
    // IDLE    | waiting for a sample or a pending flush
    // STEP    | strobe the filter with the registered sample
    // CAPTURE | filter output valid; keep it if primed and on phase 0
    // FLUSH   | strobe zeros TAPS+LAT times to clear the filter history

    localparam int PRIME = TAPS + LAT;
    localparam int CW    = $clog2(PRIME + 1);
    localparam int DW    = (DEC > 1) ? $clog2(DEC) : 1;
    localparam logic [CW-1:0] PRIME_C    = CW'(PRIME);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(PRIME - 1);
    localparam logic [DW-1:0] PHASE_LAST = DW'(DEC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STEP    = 2'd1,
        S_CAPTURE = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_strobe_cnt;
    logic [CW-1:0]    r_flush_cnt;
    logic [DW-1:0]    r_dec_phase;
    logic             r_flush_pend;
    logic             r_start;
    logic             r_busy;
    logic             r_primed;
    logic [WIDTH-1:0] r_fir_data;

    logic [WIDTH-1:0] r_fifo_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_fifo_cnt;

    logic w_accept;
    logic w_push;
    logic w_pop;

    assign in_ready = (r_state == S_IDLE) && (r_fifo_cnt < 2'd2) && !r_flush_pend && !flush_i;
    assign w_accept = in_valid && in_ready;
    assign w_push   = (r_state == S_CAPTURE) && (r_strobe_cnt == PRIME_C) && (r_dec_phase == '0);
    assign w_pop    = out_valid && out_ready;

    assign fir_data_o  = r_fir_data;
    assign fir_start_o = r_start;
    assign fir_merge_o = r_start;
    assign busy_o      = r_busy;
    assign primed_o    = r_primed;
    assign out_valid   = (r_fifo_cnt != 2'd0);
    assign out_data    = r_fifo_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_strobe_cnt <= '0;
            r_flush_cnt  <= '0;
            r_dec_phase  <= '0;
            r_flush_pend <= 1'b0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_primed     <= 1'b0;
            r_fir_data   <= '0;
        end else begin
            if (flush_i && (r_state != S_IDLE)) begin
                r_flush_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (flush_i || r_flush_pend) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= '0;
                        r_fir_data  <= '0;
                        r_start     <= 1'b1;
                        r_busy      <= 1'b1;
                    end else if (w_accept) begin
                        r_state    <= S_STEP;
                        r_fir_data <= in_data;
                        r_start    <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_STEP: begin
                    r_start <= 1'b0;
                    r_state <= S_CAPTURE;
                    if (r_strobe_cnt != PRIME_C) begin
                        r_strobe_cnt <= r_strobe_cnt + 1'b1;
                        r_primed     <= (r_strobe_cnt + 1'b1) == PRIME_C;
                    end
                end
                S_CAPTURE: begin
                    if (r_strobe_cnt == PRIME_C) begin
                        r_dec_phase <= (r_dec_phase == PHASE_LAST) ? '0 : r_dec_phase + 1'b1;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_FLUSH: begin
                    // Requests arriving during the flush merge into it.
                    if (r_flush_cnt == FLUSH_LAST) begin
                        r_state      <= S_IDLE;
                        r_start      <= 1'b0;
                        r_busy       <= 1'b0;
                        r_strobe_cnt <= '0;
                        r_dec_phase  <= '0;
                        r_primed     <= 1'b0;
                        r_flush_pend <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fifo_mem[0] <= '0;
            r_fifo_mem[1] <= '0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_fifo_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= fir_data_i;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

endmodule
